cluster_dma_transfer_retire_tracker: RTL
========================================

# cluster_dma_transfer_retire_tracker

Tracks in-flight cluster DMA transfers between the frontend and the DMA backend. It allocates a ring slot to each issued transfer and accepts completions from the backend in any order. It emits exactly one in-order `retire_o` pulse per transfer, so the transfer-ID completed counter only ever advances in issue order. It sits between the frontend issue path, the backend completion path, and the ID generator's `issue_i`/`retire_i` inputs.

## Interface
- `NumOutstanding`, default 16: ring depth; power of two, ≥ 2.
- `SlotWidth`, default `$clog2(NumOutstanding)`: width of slot indices (derived).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `issue_valid_i`  in  1  frontend pushes a new transfer.
- `issue_ready_o`  out  1  a slot is free; issue is accepted when valid && ready.
- `issue_slot_o`  out  SlotWidth  slot allocated to the transfer accepted this cycle; the backend carries it as its tag.
- `done_valid_i`  in  1  backend reports completion of one transfer.
- `done_slot_i`  in  SlotWidth  slot of the completed transfer.
- `retire_o`  out  1  one-cycle pulse per in-order retirement; drives the ID generator's `retire_i`.
- `outstanding_o`  out  SlotWidth+1  number of allocated, not yet retired slots.
- `err_o`  out  1  registered one-cycle pulse on an illegal completion.

## Operation
- **State**
  - `head_q`: oldest outstanding slot.
  - `tail_q`: next slot to allocate.
  - `count_q`: 0..NumOutstanding.
  - `done_q[NumOutstanding]`: one completion bit per slot.
- **Issue**
  - `issue_ready_o = (count_q != NumOutstanding)`.
  - `issue_slot_o = tail_q`.
  - On accept: clear `done_q[tail_q]`, then `tail_q++` mod N.
- **Completion**
  - Slot s is outstanding iff `((s - head_q) mod N) < count_q`, evaluated on registered state.
  - Legal completion: the slot is outstanding and `done_q[s]==0`. Set `done_q[s]`.
  - Illegal completion: the slot is not outstanding, or the slot is already done. No state change; `err_o=1` next cycle.
- **Retire**
  - `retire_o = (count_q != 0) && done_q[head_q]`, combinational from registered state.
  - On retire: clear `done_q[head_q]`, then `head_q++` mod N.
  - At most one retire per cycle.
  - A contiguous run of k done slots at the head drains in k consecutive cycles.
- **Count**
  - `count_d = count_q + issue_accept - retire_o`.
  - Simultaneous accept and retire leaves the count unchanged.
  - `outstanding_o = count_q`.
- **Arithmetic:** pointers wrap naturally at SlotWidth bits, since N is a power of two.

## Timing
- **Reset values:** `head_q = tail_q = count_q = 0`; all `done_q = 0`. Resulting outputs: `retire_o=0`, `issue_ready_o=1`, `issue_slot_o=0`, `outstanding_o=0`, `err_o=0`.
- **Issue latency:** a slot accepted in cycle t is counted in `outstanding_o` from t+1 and can legally complete from t+1.
- **Completion in the same cycle as its issue:** illegal; `err_o` pulses.
- **Retire latency:** a head-slot completion in cycle t produces `retire_o` in t+1. A non-head completion retires in the cycle after the head run reaches it.
- **Full ring:** `issue_ready_o` depends only on `count_q`. A retire in the same cycle does not free a slot until the next cycle. There is no combinational path from `retire_o` to `issue_ready_o`.
- **Empty ring:** `retire_o=0` regardless of stale `done_q` bits.
- **Completion of the head slot in the cycle it would retire:** cannot occur, since the bit is already set. It is treated as a duplicate and `err_o` pulses.
- **Issue, completion and retire in one cycle:** all three updates apply independently. Issue and retire never target the same slot while `count_q != 0 && count_q != N`. When full, issue is blocked.
- **Reset mid-operation:** all state clears asynchronously; in-flight transfers are lost. The ID generator is reset in the same domain.
- **Backpressure:** `issue_valid_i` may drop without acceptance; there is no requirement to hold it.

## Test plan
1. **In-order flow:** from reset, issue 3 in cycles 0–2 (slots 0, 1, 2), then complete slots 0, 1, 2 in cycles 4, 5, 6 -> `retire_o` high in cycles 5, 6, 7; `outstanding_o` returns to 0 in cycle 8.
2. **Out-of-order completion:** issue 4, then complete slots 3, 1, 2 -> no retire. Then complete slot 0 in cycle t -> `retire_o` high in t+1..t+4 (4 pulses); no `err_o`.
3. **Full ring, N=16:** issue 16 -> `issue_ready_o=0` and `outstanding_o=16`. Complete slot 0 -> retire in the next cycle; `issue_ready_o=1` one cycle after that; the next issue gets `issue_slot_o=0`.
4. **Wrap-around:** run 40 transfers with random in-order and out-of-order completions while keeping at most 16 outstanding -> exactly 40 retire pulses, in issue order; slots wrap 15→0; `err_o` never asserts.
5. **Illegal completion:** complete slot 5 with 2 outstanding, duplicate a completion of slot 1, and complete a slot in the same cycle it is issued -> `err_o` pulses once for each, one cycle later; `retire_o` and `outstanding_o` are unaffected.
6. **Reset mid-operation:** with 7 outstanding and 3 done, assert `rst_ni=0` -> all outputs take their reset values immediately. After release, the first issue gets slot 0 and behaviour matches scenario 1.

Source files
------------

// File: rtl/cluster_dma_transfer_retire_tracker_if.sv
// Issue, completion and retire signals between the DMA frontend/backend and the
// in-order retire tracker.
interface cluster_dma_transfer_retire_tracker_if #(
  parameter int unsigned NumOutstanding = 16,
  parameter int unsigned SlotWidth      = $clog2(NumOutstanding)
);
  // Issue handshake: a transfer is accepted on any cycle where issue_valid_i && issue_ready_o;
  // valid may drop without acceptance, and ready depends only on registered occupancy.
  logic                 issue_valid_i;
  logic                 issue_ready_o;
  logic [SlotWidth-1:0] issue_slot_o;
  logic                 done_valid_i;
  logic [SlotWidth-1:0] done_slot_i;
  logic                 retire_o;
  logic [SlotWidth:0]   outstanding_o;
  logic                 err_o;

  modport master (
    output issue_valid_i,
    output done_valid_i,
    output done_slot_i,
    input  issue_ready_o,
    input  issue_slot_o,
    input  retire_o,
    input  outstanding_o,
    input  err_o
  );

  modport slave (
    input  issue_valid_i,
    input  done_valid_i,
    input  done_slot_i,
    output issue_ready_o,
    output issue_slot_o,
    output retire_o,
    output outstanding_o,
    output err_o
  );
endinterface

// File: rtl/cluster_dma_transfer_retire_tracker.sv
// Ring of transfer slots: allocates on issue, accepts out-of-order completions,
// and retires strictly in issue order, one per cycle.
module cluster_dma_transfer_retire_tracker #(
  parameter int unsigned NumOutstanding = 16,
  parameter int unsigned SlotWidth      = $clog2(NumOutstanding)
) (
  input  logic clk_i,
  input  logic rst_ni,
  cluster_dma_transfer_retire_tracker_if.slave trk
);

  localparam logic [SlotWidth:0]   FullCount = (SlotWidth+1)'(NumOutstanding);
  localparam logic [SlotWidth:0]   CountOne  = (SlotWidth+1)'(1);
  localparam logic [SlotWidth:0]   CountZero = '0;
  localparam logic [SlotWidth-1:0] SlotOne   = SlotWidth'(1);

  logic [SlotWidth-1:0]      head_q, head_d;
  logic [SlotWidth-1:0]      tail_q, tail_d;
  logic [SlotWidth:0]        count_q, count_d;
  logic [NumOutstanding-1:0] done_q, done_d;
  logic                      err_q, err_d;

  logic                 issue_ready;
  logic                 issue_accept;
  logic                 retire;
  logic [SlotWidth-1:0] done_offset;
  logic                 slot_outstanding;
  logic                 done_legal;

  // Occupancy comes only from registered state, so ready never sees a same-cycle retire.
  assign issue_ready  = (count_q != FullCount);
  assign issue_accept = trk.issue_valid_i & issue_ready;
  assign retire       = (count_q != CountZero) & done_q[head_q];

  // Distance from head wraps at SlotWidth bits; anything inside the occupied window is live.
  assign done_offset      = trk.done_slot_i - head_q;
  assign slot_outstanding = ({1'b0, done_offset} < count_q);
  assign done_legal       = trk.done_valid_i & slot_outstanding & ~done_q[trk.done_slot_i];

  always_comb begin
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = trk.done_valid_i & ~done_legal;

    // Issue, completion and retire never touch the same bit in one cycle:
    // a legal completion is never the tail, and the head is already done when it retires.
    if (issue_accept) begin
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + SlotOne;
    end
    if (done_legal) begin
      done_d[trk.done_slot_i] = 1'b1;
    end
    if (retire) begin
      done_d[head_q] = 1'b0;
      head_d         = head_q + SlotOne;
    end

    if (issue_accept && !retire) begin
      count_d = count_q + CountOne;
    end else if (!issue_accept && retire) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign trk.issue_ready_o = issue_ready;
  assign trk.issue_slot_o  = tail_q;
  assign trk.retire_o      = retire;
  assign trk.outstanding_o = count_q;
  assign trk.err_o         = err_q;

endmodule
